// File: rtl/cpu_ctrl_pkg.sv
// Shared types and widths for the CPU step controller.
// State encoding matches the 2-bit debug output driven to the HEX displays.
package cpu_ctrl_pkg;

    localparam int PC_W   = 16;
    localparam int STEP_W = 16;

    typedef enum logic [1:0] {
        ST_HALT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    function automatic logic bp_hit(
        input logic            en,
        input logic [PC_W-1:0] pc,
        input logic [PC_W-1:0] addr
    );
        return en && (pc == addr);
    endfunction

endpackage

// File: rtl/cpu_step_controller_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, level debounce and rising-edge press pulse.
// The stable level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/cpu_step_controller.sv
// Generates the CPU clock-enable: debounced single-step, divided free-run, halt stop.
// Optional breakpoint compare in RUN is enabled with `define BREAKPOINT_EN.
module cpu_step_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 5000000,
    parameter int CNT_W           = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        halt_req,
    input  logic [15:0] pc_in,
    input  logic [15:0] bp_addr,
    input  logic        bp_en,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [15:0] step_count
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

    logic              press;
    logic              run_s1;
    logic              run_sync;
    state_t            st_q;
    state_t            st_d;
    logic [CNT_W-1:0]  div_q;
    logic [CNT_W-1:0]  div_d;
    logic              ce_d;
    logic              tick;
    logic [STEP_W-1:0] count_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_step_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .press(press)
    );

`ifdef BREAKPOINT_EN
    // First tick after entering RUN skips the compare so we can leave a breakpoint.
    logic first_q;
    logic first_d;
`else
    logic unused_bp;
    assign unused_bp = ^{pc_in, bp_addr, bp_en};
`endif

    assign tick = (st_q == ST_RUN) && (div_q == DIV_LAST);

    always_comb begin
        st_d  = st_q;
        div_d = '0;
        ce_d  = 1'b0;
`ifdef BREAKPOINT_EN
        first_d = first_q;
`endif
        unique case (st_q)
            ST_HALT: begin
                if (run_sync) begin
                    st_d = ST_RUN;
`ifdef BREAKPOINT_EN
                    first_d = 1'b1;
`endif
                end else if (press) begin
                    ce_d = 1'b1;
                end
            end
            ST_RUN: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (halt_req) begin
                    st_d = ST_STOPPED;
                end else if (!run_sync) begin
                    st_d = ST_HALT;
                end else if (tick) begin
`ifdef BREAKPOINT_EN
                    first_d = 1'b0;
                    if (!first_q && bp_hit(bp_en, pc_in, bp_addr)) begin
                        st_d = ST_STOPPED;
                    end else begin
                        ce_d = 1'b1;
                    end
`else
                    ce_d = 1'b1;
`endif
                end
            end
            ST_STOPPED: begin
                if (!run_sync) begin
                    st_d = ST_HALT;
                end
            end
            default: begin
                st_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_s1   <= 1'b0;
            run_sync <= 1'b0;
            st_q     <= ST_HALT;
            div_q    <= '0;
            cpu_ce   <= 1'b0;
            count_q  <= '0;
        end else begin
            run_s1   <= run_sw;
            run_sync <= run_s1;
            st_q     <= st_d;
            div_q    <= div_d;
            // Guard keeps the enable a strict single-cycle pulse.
            cpu_ce   <= ce_d & ~cpu_ce;
            count_q  <= count_q + {{(STEP_W-1){1'b0}}, cpu_ce};
        end
    end

`ifdef BREAKPOINT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
        end else begin
            first_q <= first_d;
        end
    end
`endif

    assign state      = st_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller (DEBOUNCE_CYCLES=4, RUN_DIV=8).
// Expected pulse cycles are queued at stimulus time and matched on cpu_ce.
module tb_cpu_step_controller;

    localparam int DEB = 4;
    localparam int DIV = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        step_btn;
    logic        run_sw;
    logic        halt_req;
    logic [15:0] pc_in;
    logic [15:0] bp_addr;
    logic        bp_en;
    logic        cpu_ce;
    logic [1:0]  state;
    logic [15:0] step_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    logic prev_ce = 1'b0;

    typedef struct {
        bit          bounce;
        int          hold;
        bit          pulse;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[5];

    cpu_step_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV),
        .CNT_W          (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_btn  (step_btn),
        .run_sw    (run_sw),
        .halt_req  (halt_req),
        .pc_in     (pc_in),
        .bp_addr   (bp_addr),
        .bp_en     (bp_en),
        .cpu_ce    (cpu_ce),
        .state     (state),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign pc_in = step_count;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", name, act, want, cyc);
        end
    endtask

    task automatic chk_empty(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (cpu_ce) begin
            if (prev_ce) chk("ce_back_to_back", 1, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", cyc, 0);
            end else begin
                chk("pulse_cycle", cyc, exp_q.pop_front());
            end
        end
        prev_ce = cpu_ce;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts on a negedge; pulse expected DEB+3 cycles after the final rise.
    task automatic press(input bit bounce, input int hold, input bit pulse);
        if (bounce) begin
            step_btn = 1'b1;
            wait_cyc(1);
            step_btn = 1'b0;
            wait_cyc(1);
        end
        step_btn = 1'b1;
        if (pulse) exp_q.push_back(cyc + DEB + 3);
        wait_cyc(hold);
        step_btn = 1'b0;
        wait_cyc(16);
    endtask

    initial begin
        int c;
        vecs[0] = '{1'b1, 10, 1'b1, 16'd1};
        vecs[1] = '{1'b0, 3,  1'b0, 16'd1};
        vecs[2] = '{1'b0, 4,  1'b1, 16'd2};
        vecs[3] = '{1'b0, 2,  1'b0, 16'd2};
        vecs[4] = '{1'b0, 7,  1'b1, 16'd3};

        rst = 1'b1;
        step_btn = 1'b0;
        run_sw = 1'b0;
        halt_req = 1'b0;
        bp_addr = 16'h0005;
        bp_en = 1'b0;
        wait_cyc(3);
        chk("reset_state", state, 0);
        chk("reset_ce", cpu_ce, 0);
        chk("reset_count", step_count, 0);
        rst = 1'b0;
        wait_cyc(2);

        for (int i = 0; i < 5; i++) begin
            press(vecs[i].bounce, vecs[i].hold, vecs[i].pulse);
            chk_empty($sformatf("vec%0d_pulses", i));
            chk($sformatf("vec%0d_count", i), step_count, vecs[i].count);
            chk($sformatf("vec%0d_state", i), state, 0);
        end

        // Free-run: RUN seen 3 cycles after run_sw, pulses at +11, +19, ...
        c = cyc;
        run_sw = 1'b1;
        for (int n = 0; n < 12; n++) exp_q.push_back(c + 11 + DIV * n);
        wait_cyc(2);
        chk("run_pre_state", state, 0);
        wait_cyc(1);
        chk("run_entry_state", state, 1);
        wait_cyc(97);
        run_sw = 1'b0;
        wait_cyc(2);
        chk("run_exit_pre", state, 1);
        wait_cyc(1);
        chk("run_exit_state", state, 0);
        wait_cyc(20);
        chk_empty("run_pulses");
        chk("run_count", step_count, 16'd15);

        // Halt request on the second tick cycle wins over the pulse.
        c = cyc;
        run_sw = 1'b1;
        exp_q.push_back(c + 11);
        wait_cyc(18);
        halt_req = 1'b1;
        wait_cyc(1);
        halt_req = 1'b0;
        chk("halt_stopped", state, 2);
        press(1'b0, 6, 1'b0);
        chk("halt_hold", state, 2);
        chk_empty("halt_pulses");
        chk("halt_count", step_count, 16'd16);
        run_sw = 1'b0;
        wait_cyc(2);
        chk("halt_exit_pre", state, 2);
        wait_cyc(1);
        chk("halt_exit_state", state, 0);

        // Wrap: preload the counter, then one more step.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        wait_cyc(1);
        press(1'b0, 5, 1'b1);
        chk_empty("wrap_pulses");
        chk("wrap_count", step_count, 16'h0000);

        // Reset in the middle of RUN.
        press(1'b0, 5, 1'b1);
        c = cyc;
        run_sw = 1'b1;
        exp_q.push_back(c + 11);
        exp_q.push_back(c + 19);
        wait_cyc(20);
        rst = 1'b1;
        run_sw = 1'b0;
        wait_cyc(1);
        chk("rst_state", state, 0);
        chk("rst_ce", cpu_ce, 0);
        chk("rst_count", step_count, 0);
        rst = 1'b0;
        wait_cyc(15);
        chk_empty("rst_pulses");

`ifdef BREAKPOINT_EN
        bp_en = 1'b1;
        c = cyc;
        run_sw = 1'b1;
        for (int n = 0; n < 5; n++) exp_q.push_back(c + 11 + DIV * n);
        wait_cyc(50);
        chk("bp_pre_state", state, 1);
        wait_cyc(1);
        chk("bp_state", state, 2);
        chk("bp_count", step_count, 16'd5);
        run_sw = 1'b0;
        wait_cyc(4);
        chk("bp_halt", state, 0);
        c = cyc;
        run_sw = 1'b1;
        exp_q.push_back(c + 11);
        wait_cyc(12);
        run_sw = 1'b0;
        chk("bp_resume_count", step_count, 16'd6);
        wait_cyc(10);
        chk_empty("bp_pulses");
        chk("bp_end_state", state, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
